// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder.
// Phase length, default device ID and the protocol FSM states.
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ID,
        SUB,
        WDATA,
        RDATA,
        IGNORE
    } sccb_state_e;

    localparam int         SCCB_PHASE_BITS = 9;
    localparam logic [7:0] SCCB_DEFAULT_ID = 8'h42;
    localparam logic [3:0] SCCB_LAST_BIT   = 4'(SCCB_PHASE_BITS - 1);

    function automatic logic sccb_mid_byte(input logic [3:0] n);
        return (n != 4'd0) && (n < 4'd8);
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// SIO_C/SIO_D resynchronizer into XCLK plus bus event pulses.
// Stages preset high so reset looks like an idle bus.
module sccb_line_sync #(
    parameter int STAGES = 2
) (
    input  logic XCLK,
    input  logic RST_N,
    input  logic SIO_C,
    input  logic SIO_D,
    output logic d,
    output logic rise,
    output logic fall,
    output logic start,
    output logic stop
);

    logic [STAGES-1:0] c_sr;
    logic [STAGES-1:0] d_sr;
    logic              c;
    logic              cp;
    logic              dp;

    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            c_sr <= '1;
            d_sr <= '1;
            cp   <= 1'b1;
            dp   <= 1'b1;
        end else begin
            c_sr <= {c_sr[STAGES-2:0], SIO_C};
            d_sr <= {d_sr[STAGES-2:0], SIO_D};
            cp   <= c_sr[STAGES-1];
            dp   <= d_sr[STAGES-1];
        end
    end

    assign c     = c_sr[STAGES-1];
    assign d     = d_sr[STAGES-1];
    assign rise  = c & ~cp;
    assign fall  = ~c & cp;
    assign start = c & cp & dp & ~d;
    assign stop  = c & cp & ~dp & d;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target: decodes 3-phase write and 2-phase write/read
// transactions for DEVICE_ID and exposes a register-file port.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID   = SCCB_DEFAULT_ID,
    parameter int         SYNC_STAGES = 2,
    parameter bit         DRIVE_ACK   = 1'b1
) (
    input  logic       XCLK,
    input  logic       RST_N,
    input  logic       SIO_C,
    inout  wire        SIO_D,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err
);

    sccb_state_e state_q;
    sccb_state_e state_d;
    logic [3:0]  bcnt;
    logic [3:0]  done_bits;
    logic [7:0]  shreg;
    logic        pend;
    logic        sda_low;
    logic        d;
    logic        rise;
    logic        fall;
    logic        start;
    logic        stop;
    logic        last;
    logic        id_hit;
    logic        counting;
    logic        capture;
    logic        ack_drive;

    sccb_line_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .XCLK (XCLK),
        .RST_N(RST_N),
        .SIO_C(SIO_C),
        .SIO_D(SIO_D),
        .d    (d),
        .rise (rise),
        .fall (fall),
        .start(start),
        .stop (stop)
    );

    assign SIO_D  = (sda_low && RST_N) ? 1'b0 : 1'bz;
    assign last   = (bcnt == SCCB_LAST_BIT);
    assign id_hit = (shreg[7:1] == DEVICE_ID[7:1]);

    // START/STOP always follow a SIO_C rise that carries no data bit
    assign done_bits = (pend && bcnt != 4'd0) ? bcnt - 4'd1 : bcnt;

    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ID;
        end else if (stop) begin
            state_d = IDLE;
        end else if (rise && last) begin
            unique case (state_q)
                ID:           state_d = !id_hit ? IGNORE
                                      : (shreg[0] ? RDATA : SUB);
                SUB:          state_d = WDATA;
                WDATA, RDATA: state_d = IGNORE;
                default:      state_d = state_q;
            endcase
        end
    end

    always_comb begin
        counting  = 1'b0;
        capture   = 1'b0;
        ack_drive = 1'b0;
        unique case (state_q)
            ID: begin
                counting  = 1'b1;
                capture   = 1'b1;
                ack_drive = DRIVE_ACK && id_hit;
            end
            SUB, WDATA: begin
                counting  = 1'b1;
                capture   = 1'b1;
                ack_drive = DRIVE_ACK;
            end
            RDATA:   counting = 1'b1;
            default: counting = 1'b0;
        endcase
    end

    always_ff @(posedge XCLK or negedge RST_N) begin
        if (!RST_N) begin
            bcnt      <= '0;
            shreg     <= '0;
            pend      <= 1'b0;
            sda_low   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            err    <= 1'b0;
            if (start || stop) begin
                err     <= sccb_mid_byte(done_bits);
                bcnt    <= '0;
                pend    <= 1'b0;
                sda_low <= 1'b0;
                if (stop) busy <= 1'b0;
            end else if (rise) begin
                pend <= 1'b1;
                if (counting) begin
                    bcnt <= last ? 4'd0 : bcnt + 4'd1;
                    if (capture && !last) shreg <= {shreg[6:0], d};
                    if (state_q == WDATA && bcnt == 4'd7)
                        reg_wdata <= {shreg[6:0], d};
                    if (last) begin
                        if (state_q == ID && id_hit) busy <= 1'b1;
                        if (state_q == SUB) reg_addr <= shreg;
                        if (state_q == WDATA) reg_we <= 1'b1;
                    end
                end
            end else if (fall) begin
                pend    <= 1'b0;
                sda_low <= 1'b0;
                if (state_q == RDATA) begin
                    // first fall in RDATA ends the ID ack bit
                    if (bcnt == 4'd0) begin
                        shreg   <= reg_rdata;
                        sda_low <= ~reg_rdata[7];
                    end else if (!last) begin
                        shreg   <= {shreg[6:0], 1'b0};
                        sda_low <= ~shreg[6];
                    end
                end else if (last && ack_drive) begin
                    sda_low <= 1'b1;
                end
            end
        end
    end

endmodule
